// File: rtl/wb_stage.sv
// Write-back pipeline stage: holds the MEM->WB instruction, aligns and extends
// load data, drives the register-file write port and counts retired instructions.
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             mem_valid,
    input  logic [31:0]      mem_pc,
    input  logic             mem_we,
    input  logic [4:0]       mem_waddr,
    input  logic [31:0]      mem_result,
    input  logic             mem_is_load,
    input  logic [2:0]       mem_load_op,
    input  logic [1:0]       mem_addr_lo,
    input  logic [31:0]      dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             wb_valid,
    output logic [31:0]      wb_pc,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_result;
    logic        wb_is_load;
    logic [2:0]  wb_load_op;
    logic [1:0]  wb_addr_lo;
    logic        first_cycle;
    logic        written;
    logic [31:0] hold_data;

    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // stall freezes the whole WB register; a new instruction enters only when stall=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_pc      <= 32'd0;
            wb_we      <= 1'b0;
            wb_waddr   <= 5'd0;
            wb_result  <= 32'd0;
            wb_is_load <= 1'b0;
            wb_load_op <= 3'd0;
            wb_addr_lo <= 2'd0;
        end else if (!stall) begin
            wb_valid   <= mem_valid;
            wb_pc      <= mem_pc;
            wb_we      <= mem_we;
            wb_waddr   <= mem_waddr;
            wb_result  <= mem_result;
            wb_is_load <= mem_is_load;
            wb_load_op <= mem_load_op;
            wb_addr_lo <= mem_addr_lo;
        end
    end

    // The memory word is only valid in the first WB cycle, so it is captured
    // then and replayed from hold_data for the rest of a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_cycle <= 1'b0;
            hold_data   <= 32'd0;
        end else begin
            first_cycle <= !stall;
            if (first_cycle) begin
                hold_data <= dmem_rdata;
            end
        end
    end

    // Once an instruction has written under stall, suppress further writes until it leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            written <= 1'b0;
        end else if (!stall) begin
            written <= 1'b0;
        end else if (wb_valid) begin
            written <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_valid && !stall) begin
            retire_cnt <= retire_cnt + CNT_ONE;
        end
    end

    always_comb begin
        load_word = first_cycle ? dmem_rdata : hold_data;
        load_byte = load_word[7:0];
        case (wb_addr_lo)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = wb_addr_lo[1] ? load_word[31:16] : load_word[15:0];
        case (wb_load_op)
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LBU:  load_data = {24'd0, load_byte};
            OP_LHU:  load_data = {16'd0, load_half};
            default: load_data = load_word;
        endcase
    end

    assign rf_wdata = wb_is_load ? load_data : wb_result;
    assign rf_waddr = wb_waddr;
    assign rf_we    = wb_valid && wb_we && (wb_waddr != 5'd0) && !written;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed instructions feed a write scoreboard drained by a
// monitor on every rf_we; counter, stall and reset behaviour are checked directly.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_result;
    logic        mem_is_load;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dmem_rdata;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] retire_cnt;

    logic        rf_we4;
    logic [4:0]  rf_waddr4;
    logic [31:0] rf_wdata4;
    logic        wb_valid4;
    logic [31:0] wb_pc4;
    logic [3:0]  retire_cnt4;

    logic [36:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_cnt;
    logic [31:0] base_cnt;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_result(mem_result),
        .mem_is_load(mem_is_load), .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
        .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .retire_cnt(retire_cnt)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_result(mem_result),
        .mem_is_load(mem_is_load), .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
        .dmem_rdata(dmem_rdata), .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .wb_valid(wb_valid4), .wb_pc(wb_pc4), .retire_cnt(retire_cnt4)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // driver: present one MEM instruction for a single edge, then fall back to a bubble
    task automatic send(input logic v, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] res, input logic ld,
                        input logic [2:0] op, input logic [1:0] lo,
                        input logic [31:0] rdata, input logic [31:0] expw);
        mem_valid   = v;
        mem_pc      = pc;
        mem_we      = we;
        mem_waddr   = wa;
        mem_result  = res;
        mem_is_load = ld;
        mem_load_op = op;
        mem_addr_lo = lo;
        tick();
        mem_valid  = 1'b0;
        dmem_rdata = rdata;
        if (v && we && wa != 5'd0) exp_q.push_back({wa, expw});
        if (v) exp_cnt++;
    endtask

    task automatic check_cnt(input string tag);
        tick();
        @(negedge clk);
        check({tag, " retire_cnt"}, retire_cnt, exp_cnt);
        check({tag, " retire_cnt4"}, {28'd0, retire_cnt4}, {28'd0, exp_cnt[3:0]});
        check({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd0);
    endtask

    // monitor / scoreboard: every register-file write must match the oldest expectation
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rf_write: unexpected write addr %0d data %h", rf_waddr, rf_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
                check("rf_wdata", rf_wdata, e[31:0]);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_cnt = 32'd0;
        rst = 1'b1;
        stall = 1'b0;
        mem_valid = 1'b0;
        mem_pc = 32'd0;
        mem_we = 1'b0;
        mem_waddr = 5'd0;
        mem_result = 32'd0;
        mem_is_load = 1'b0;
        mem_load_op = 3'd0;
        mem_addr_lo = 2'd0;
        dmem_rdata = 32'd0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset rf_we", {31'd0, rf_we}, 32'd0);
        check("reset rf_wdata", rf_wdata, 32'd0);
        check("reset wb_pc", wb_pc, 32'd0);
        check("reset retire_cnt", retire_cnt, 32'd0);

        // ALU write
        send(1, 32'h100, 1, 5'd5, 32'h1234_5678, 0, 3'd0, 2'd0, 32'd0, 32'h1234_5678);
        @(negedge clk);
        check("alu wb_valid", {31'd0, wb_valid}, 32'd1);
        check("alu wb_pc", wb_pc, 32'h100);
        check_cnt("alu");

        // loads on one memory word, all widths and offsets
        send(1, 32'h104, 1, 5'd1, 32'h0, 1, 3'b000, 2'd0, 32'h80F1_7F82, 32'hFFFF_FF82);
        send(1, 32'h108, 1, 5'd2, 32'h0, 1, 3'b100, 2'd3, 32'h80F1_7F82, 32'h0000_0080);
        send(1, 32'h10C, 1, 5'd3, 32'h0, 1, 3'b001, 2'd2, 32'h80F1_7F82, 32'hFFFF_80F1);
        send(1, 32'h110, 1, 5'd4, 32'h0, 1, 3'b101, 2'd1, 32'h80F1_7F82, 32'h0000_7F82);
        send(1, 32'h114, 1, 5'd6, 32'h0, 1, 3'b010, 2'd2, 32'h80F1_7F82, 32'h80F1_7F82);
        send(1, 32'h118, 1, 5'd7, 32'h0, 1, 3'b000, 2'd1, 32'h80F1_7F82, 32'h0000_007F);
        send(1, 32'h11C, 1, 5'd8, 32'h0, 1, 3'b100, 2'd2, 32'h80F1_7F82, 32'h0000_00F1);
        send(1, 32'h120, 1, 5'd9, 32'h0, 1, 3'b001, 2'd1, 32'h80F1_7F82, 32'h0000_7F82);
        send(1, 32'h124, 1, 5'd10, 32'h0, 1, 3'b011, 2'd1, 32'h80F1_7F82, 32'h80F1_7F82);
        send(1, 32'h128, 1, 5'd11, 32'h0, 1, 3'b101, 2'd3, 32'h1234_F00D, 32'h0000_1234);
        check_cnt("loads");

        // write to x0 retires without a write; bubble neither
        send(1, 32'h130, 1, 5'd0, 32'hFFFF_FFFF, 0, 3'd0, 2'd0, 32'd0, 32'd0);
        send(0, 32'h134, 1, 5'd12, 32'h5555_5555, 0, 3'd0, 2'd0, 32'd0, 32'd0);
        check_cnt("x0/bubble");

        // load held under a three-cycle stall while the memory word changes
        base_cnt = exp_cnt;
        send(1, 32'h200, 1, 5'd7, 32'h0, 1, 3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        stall = 1'b1;
        mem_valid = 1'b1;
        mem_pc = 32'hBAD0;
        mem_waddr = 5'd9;
        mem_result = 32'h9999_9999;
        mem_is_load = 1'b0;
        tick();
        dmem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall rf_we", {31'd0, rf_we}, 32'd0);
            check("stall rf_wdata", rf_wdata, 32'hCAFE_F00D);
            check("stall wb_pc", wb_pc, 32'h200);
            check("stall retire_cnt", retire_cnt, base_cnt);
            tick();
        end
        stall = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        check("unstall rf_we", {31'd0, rf_we}, 32'd0);
        check("unstall retire_cnt", retire_cnt, base_cnt);
        check_cnt("stall");

        // reset while a load is held under stall
        send(1, 32'h300, 1, 5'd8, 32'h0, 1, 3'b010, 2'd0, 32'h0BAD_F00D, 32'h0BAD_F00D);
        stall = 1'b1;
        tick();
        @(negedge clk);
        check("held rf_we", {31'd0, rf_we}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        exp_cnt = 32'd0;
        @(negedge clk);
        check("rst-stall wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst-stall rf_we", {31'd0, rf_we}, 32'd0);
        check("rst-stall rf_wdata", rf_wdata, 32'd0);
        check("rst-stall retire_cnt", retire_cnt, 32'd0);
        check("rst-stall retire_cnt4", {28'd0, retire_cnt4}, 32'd0);

        // 17 retirements from reset: 4-bit counter wraps to 1
        for (int i = 1; i <= 17; i++) begin
            send(1, 32'h400 + 32'(4 * i), 1'b1, (i % 2 == 1) ? 5'(i) : 5'd0,
                 32'h1000 + 32'(i), 0, 3'd0, 2'd0, 32'd0, 32'h1000 + 32'(i));
        end
        check_cnt("wrap");
        check("wrap retire_cnt 17", retire_cnt, 32'd17);
        check("wrap retire_cnt4 1", {28'd0, retire_cnt4}, 32'd1);

        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending writes expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
